// File: rtl/rv32i_dbg_pkg.sv
// rv32i_dbg_pkg
// Shared definitions for the rv32i debug/trace blocks:
//   - state_t : trace buffer FSM encoding (IDLE/CAPTURE/DONE)
//   - field widths and bit offsets of a packed trace entry
//
// Packed entry layout, MSB first:
//   {has_reg, has_mem, reg_addr[4:0], reg_data[31:0],
//    mem_addr[31:0], mem_data[31:0], mem_mask[3:0], ts[TS_W-1:0]}
// The offsets below are relative to the bit just above the timestamp,
// so a field's absolute position is TS_W + OFF_*.
package rv32i_dbg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;
  localparam int MASK_W = 4;

  localparam int OFF_MASK   = 0;
  localparam int OFF_MDATA  = OFF_MASK + MASK_W;
  localparam int OFF_MADDR  = OFF_MDATA + DATA_W;
  localparam int OFF_RDATA  = OFF_MADDR + DATA_W;
  localparam int OFF_RADDR  = OFF_RDATA + DATA_W;
  localparam int OFF_HASMEM = OFF_RADDR + REG_W;
  localparam int OFF_HASREG = OFF_HASMEM + 1;
  localparam int FIXED_W    = OFF_HASREG + 1;

  function automatic int entry_w(input int ts_w);
    return FIXED_W + ts_w;
  endfunction

endpackage

// File: rtl/trace_ram.sv
// trace_ram
// DEPTH x W storage for trace entries: one synchronous write port and one
// registered read port. The read register only loads when re is high, so
// the last entry read stays on rdata.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (read register only)
//   we, waddr, wdata  write port
//   re, raddr       read request; rdata is valid the cycle after re
//   rdata           registered read data
module trace_ram #(
  parameter int DEPTH = 32,
  parameter int W     = 123,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Storage array carries no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/rv32i_trace_buffer.sv
// rv32i_trace_buffer
// Commit tracer: logs register-file writes (except x0) and data-memory
// writes with a capture timestamp into a circular trace RAM, stops when
// the instruction address reaches HALT_PC, then drains oldest-first.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   arm, clear        start capture from IDLE / flush and go IDLE
//   iaddr             core instruction address (halt detection)
//   rf_wr, rf_rd_*    register write snoop
//   mem_*             data memory write snoop
//   rd_req            drain request (DONE only)
//   rd_valid, rd_*    drained entry, valid one cycle after rd_req
//   state, count      FSM state and number of held entries
//   overflow          sticky: an entry was dropped or overwritten
module rv32i_trace_buffer
  import rv32i_dbg_pkg::*;
#(
  parameter int          DEPTH        = 32,
  parameter logic [31:0] HALT_PC      = 32'h0000_003C,
  parameter bit          STOP_ON_FULL = 1'b0,
  parameter int          TS_W         = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       arm,
  input  logic                       clear,
  input  logic [31:0]                iaddr,
  input  logic                       rf_wr,
  input  logic [4:0]                 rf_rd_addr,
  input  logic [31:0]                rf_rd_data,
  input  logic                       mem_wr_en,
  input  logic [31:0]                mem_addr,
  input  logic [31:0]                mem_data,
  input  logic [3:0]                 mem_wr_mask,
  input  logic                       rd_req,
  output logic                       rd_valid,
  output logic                       rd_has_reg,
  output logic                       rd_has_mem,
  output logic [4:0]                 rd_reg_addr,
  output logic [31:0]                rd_reg_data,
  output logic [31:0]                rd_mem_addr,
  output logic [31:0]                rd_mem_data,
  output logic [3:0]                 rd_mem_mask,
  output logic [TS_W-1:0]            rd_ts,
  output logic [1:0]                 state,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = entry_w(TS_W);

  state_t          state_reg;
  logic [CW-1:0]   count_reg;
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [TS_W-1:0] ts_reg;
  logic            overflow_reg;
  logic            rd_valid_reg;

  logic            reg_ev;
  logic            mem_ev;
  logic            any_ev;
  logic            full;
  logic            halt;
  logic            do_write;
  logic            do_read;
  logic [EW-1:0]   wdata;
  logic [EW-1:0]   rdata;

  always_comb begin
    reg_ev   = rf_wr && (rf_rd_addr != 5'd0);
    mem_ev   = mem_wr_en;
    any_ev   = reg_ev || mem_ev;
    full     = (count_reg == CW'(DEPTH));
    halt     = (iaddr >= HALT_PC);
    // A full buffer in stop mode drops the event; in wrap mode the write
    // lands on the oldest slot, which is exactly wr_ptr == rd_ptr.
    do_write = (state_reg == ST_CAPTURE) && any_ev && !clear &&
               !(full && STOP_ON_FULL);
    do_read  = (state_reg == ST_DONE) && rd_req && (count_reg != '0) && !clear;
    // Fields of an absent event are stored as zero so drained entries
    // never carry stale bus values.
    wdata = {reg_ev, mem_ev,
             reg_ev ? rf_rd_addr : 5'd0,
             reg_ev ? rf_rd_data : 32'd0,
             mem_ev ? mem_addr : 32'd0,
             mem_ev ? mem_data : 32'd0,
             mem_ev ? mem_wr_mask : 4'd0,
             ts_reg};
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .W     (EW),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (do_write),
    .waddr (wr_ptr_reg),
    .wdata (wdata),
    .re    (do_read),
    .raddr (rd_ptr_reg),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      count_reg    <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      ts_reg       <= '0;
      overflow_reg <= 1'b0;
      rd_valid_reg <= 1'b0;
    end else if (clear) begin
      state_reg    <= ST_IDLE;
      count_reg    <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      overflow_reg <= 1'b0;
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= do_read;
      case (state_reg)
        ST_IDLE: begin
          if (arm) begin
            state_reg    <= ST_CAPTURE;
            ts_reg       <= '0;
            count_reg    <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            overflow_reg <= 1'b0;
          end
        end
        ST_CAPTURE: begin
          ts_reg <= ts_reg + TS_W'(1);
          if (any_ev) begin
            if (!full) begin
              wr_ptr_reg <= wr_ptr_reg + AW'(1);
              count_reg  <= count_reg + CW'(1);
            end else begin
              overflow_reg <= 1'b1;
              if (!STOP_ON_FULL) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
              end
            end
          end
          if (halt || (any_ev && full && STOP_ON_FULL)) begin
            state_reg <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (do_read) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg  <= count_reg - CW'(1);
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign state       = state_reg;
  assign count       = count_reg;
  assign overflow    = overflow_reg;
  assign rd_valid    = rd_valid_reg;
  assign rd_has_reg  = rdata[TS_W + OFF_HASREG];
  assign rd_has_mem  = rdata[TS_W + OFF_HASMEM];
  assign rd_reg_addr = rdata[TS_W + OFF_RADDR +: REG_W];
  assign rd_reg_data = rdata[TS_W + OFF_RDATA +: DATA_W];
  assign rd_mem_addr = rdata[TS_W + OFF_MADDR +: DATA_W];
  assign rd_mem_data = rdata[TS_W + OFF_MDATA +: DATA_W];
  assign rd_mem_mask = rdata[TS_W + OFF_MASK +: MASK_W];
  assign rd_ts       = rdata[TS_W-1:0];

endmodule

// File: tb/tb_rv32i_trace_buffer.sv
// tb_rv32i_trace_buffer
// Two DEPTH=4 instances share all inputs: inst0 wraps when full, inst1
// stops when full. A queue-based model per instance predicts state,
// count, overflow and drained entries after every clock.
module tb_rv32i_trace_buffer;

  typedef struct packed {
    logic        has_reg;
    logic        has_mem;
    logic [4:0]  reg_addr;
    logic [31:0] reg_data;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [3:0]  mask;
    logic [15:0] ts;
  } entry_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, arm, clear, rf_wr, mem_wr_en, rd_req;
  logic [31:0] iaddr, rf_rd_data, mem_addr, mem_data;
  logic [4:0]  rf_rd_addr;
  logic [3:0]  mem_wr_mask;

  logic        a_rd_valid, a_has_reg, a_has_mem, a_overflow;
  logic [4:0]  a_reg_addr;
  logic [31:0] a_reg_data, a_mem_addr, a_mem_data;
  logic [3:0]  a_mem_mask;
  logic [15:0] a_ts;
  logic [1:0]  a_state;
  logic [2:0]  a_count;

  logic        b_rd_valid, b_has_reg, b_has_mem, b_overflow;
  logic [4:0]  b_reg_addr;
  logic [31:0] b_reg_data, b_mem_addr, b_mem_data;
  logic [3:0]  b_mem_mask;
  logic [15:0] b_ts;
  logic [1:0]  b_state;
  logic [2:0]  b_count;

  rv32i_trace_buffer #(.DEPTH(4), .STOP_ON_FULL(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .arm(arm), .clear(clear), .iaddr(iaddr),
    .rf_wr(rf_wr), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_wr_mask(mem_wr_mask), .rd_req(rd_req), .rd_valid(a_rd_valid),
    .rd_has_reg(a_has_reg), .rd_has_mem(a_has_mem), .rd_reg_addr(a_reg_addr),
    .rd_reg_data(a_reg_data), .rd_mem_addr(a_mem_addr), .rd_mem_data(a_mem_data),
    .rd_mem_mask(a_mem_mask), .rd_ts(a_ts), .state(a_state), .count(a_count),
    .overflow(a_overflow)
  );

  rv32i_trace_buffer #(.DEPTH(4), .STOP_ON_FULL(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .arm(arm), .clear(clear), .iaddr(iaddr),
    .rf_wr(rf_wr), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_wr_mask(mem_wr_mask), .rd_req(rd_req), .rd_valid(b_rd_valid),
    .rd_has_reg(b_has_reg), .rd_has_mem(b_has_mem), .rd_reg_addr(b_reg_addr),
    .rd_reg_data(b_reg_data), .rd_mem_addr(b_mem_addr), .rd_mem_data(b_mem_data),
    .rd_mem_mask(b_mem_mask), .rd_ts(b_ts), .state(b_state), .count(b_count),
    .overflow(b_overflow)
  );

  // Reference model: one queue of held entries per instance, oldest first.
  entry_t q_a[$];
  entry_t q_b[$];
  int     m_state [2];
  bit     m_ov    [2];
  bit     m_rdv   [2];
  int     m_ts    [2];
  entry_t m_last  [2];
  int     checks = 0;
  int     errors = 0;

  task automatic model_reset();
    q_a.delete();
    q_b.delete();
    for (int k = 0; k < 2; k++) begin
      m_state[k] = 0; m_ov[k] = 1'b0; m_rdv[k] = 1'b0;
      m_ts[k] = 0; m_last[k] = '0;
    end
  endtask

  task automatic model_step(input int k);
    entry_t q[$];
    entry_t e;
    bit     reg_ev, ev;
    if (k == 0) q = q_a; else q = q_b;
    m_rdv[k] = 1'b0;
    if (clear) begin
      q.delete(); m_state[k] = 0; m_ov[k] = 1'b0;
    end else if (m_state[k] == 0) begin
      if (arm) begin
        m_state[k] = 1; m_ts[k] = 0; q.delete(); m_ov[k] = 1'b0;
      end
    end else if (m_state[k] == 1) begin
      reg_ev = rf_wr && (rf_rd_addr != 5'd0);
      ev = reg_ev || mem_wr_en;
      if (ev) begin
        e = '0;
        e.has_reg = reg_ev;
        e.has_mem = mem_wr_en;
        if (reg_ev) begin e.reg_addr = rf_rd_addr; e.reg_data = rf_rd_data; end
        if (mem_wr_en) begin
          e.mem_addr = mem_addr; e.mem_data = mem_data; e.mask = mem_wr_mask;
        end
        e.ts = 16'(m_ts[k]);
        if (q.size() < 4) q.push_back(e);
        else begin
          m_ov[k] = 1'b1;
          if (k == 1) m_state[k] = 2;
          else begin q.delete(0); q.push_back(e); end
        end
      end
      if (iaddr >= 32'h3C) m_state[k] = 2;
      m_ts[k] = (m_ts[k] + 1) % 65536;
    end else begin
      if (rd_req && q.size() > 0) begin
        m_last[k] = q.pop_front();
        m_rdv[k] = 1'b1;
      end
    end
    if (k == 0) q_a = q; else q_b = q;
  endtask

  task automatic check_inst(input int k, input logic [1:0] st, input logic [2:0] cnt,
                            input logic ov, input logic rdv, input entry_t obs);
    int exp_cnt;
    exp_cnt = (k == 0) ? q_a.size() : q_b.size();
    checks++;
    assert (st === 2'(m_state[k])) else begin
      errors++; $error("FAIL state inst%0d got %0d want %0d", k, st, m_state[k]);
    end
    checks++;
    assert (cnt === 3'(exp_cnt)) else begin
      errors++; $error("FAIL count inst%0d got %0d want %0d", k, cnt, exp_cnt);
    end
    checks++;
    assert (ov === m_ov[k]) else begin
      errors++; $error("FAIL overflow inst%0d got %0d want %0d", k, ov, m_ov[k]);
    end
    checks++;
    assert (rdv === m_rdv[k]) else begin
      errors++; $error("FAIL rd_valid inst%0d got %0d want %0d", k, rdv, m_rdv[k]);
    end
    checks++;
    assert (obs === m_last[k]) else begin
      errors++; $error("FAIL entry inst%0d got %h want %h", k, obs, m_last[k]);
    end
    if (m_rdv[k])
      $display("drain inst%0d reg=%0d:%h mem=%h:%h/%h ts=%0d", k, obs.reg_addr,
               obs.reg_data, obs.mem_addr, obs.mem_data, obs.mask, obs.ts);
  endtask

  task automatic check_all();
    check_inst(0, a_state, a_count, a_overflow, a_rd_valid,
               {a_has_reg, a_has_mem, a_reg_addr, a_reg_data, a_mem_addr,
                a_mem_data, a_mem_mask, a_ts});
    check_inst(1, b_state, b_count, b_overflow, b_rd_valid,
               {b_has_reg, b_has_mem, b_reg_addr, b_reg_data, b_mem_addr,
                b_mem_data, b_mem_mask, b_ts});
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++; $error("FAIL %s got %h want %h", tag, got, want);
    end
  endtask

  task automatic idle_inputs();
    arm = 0; clear = 0; iaddr = 32'h0; rf_wr = 0; rf_rd_addr = 0; rf_rd_data = 0;
    mem_wr_en = 0; mem_addr = 0; mem_data = 0; mem_wr_mask = 0; rd_req = 0;
  endtask

  // Apply current inputs for one clock, then compare at the falling edge.
  task automatic tick();
    model_step(0);
    model_step(1);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic reg_write(input logic [4:0] a, input logic [31:0] d);
    idle_inputs(); rf_wr = 1; rf_rd_addr = a; rf_rd_data = d; tick(); idle_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Basic capture: register write, memory write, halt, drain in order.
    arm = 1; tick(); idle_inputs();
    reg_write(5'd5, 32'h12345678);
    mem_wr_en = 1; mem_addr = 32'h1000; mem_data = 32'hDEADBEEF; mem_wr_mask = 4'hF;
    tick(); idle_inputs();
    iaddr = 32'h3C; tick(); idle_inputs();
    check_val("halt_state", 32'(a_state), 32'd2);
    check_val("halt_count", 32'(a_count), 32'd2);
    rd_req = 1; tick();
    check_val("drain0_data", a_reg_data, 32'h12345678);
    check_val("drain0_ts", 32'(a_ts), 32'd0);
    tick();
    check_val("drain1_mdata", a_mem_data, 32'hDEADBEEF);
    tick();
    check_val("drain_empty", 32'(a_rd_valid), 32'd0);
    idle_inputs(); tick();

    // Combined event, then x0 write alone.
    clear = 1; tick(); idle_inputs();
    arm = 1; tick(); idle_inputs();
    rf_wr = 1; rf_rd_addr = 5'd1; rf_rd_data = 32'hA;
    mem_wr_en = 1; mem_addr = 32'h1004; mem_data = 32'hB; mem_wr_mask = 4'b0011;
    tick(); idle_inputs();
    check_val("both_count", 32'(a_count), 32'd1);
    reg_write(5'd0, 32'h55);
    check_val("x0_count", 32'(a_count), 32'd1);
    iaddr = 32'h40; tick(); idle_inputs();
    rd_req = 1; tick(); idle_inputs();
    check_val("both_flags", {30'd0, a_has_reg, a_has_mem}, 32'd3);

    // Six writes into DEPTH=4: inst0 wraps, inst1 stops after the 5th.
    clear = 1; tick(); idle_inputs();
    arm = 1; tick(); idle_inputs();
    for (int i = 1; i <= 6; i++) begin
      reg_write(5'(i), 32'(i * 32'h11));
      if (i == 5) check_val("stop_done5", 32'(b_state), 32'd2);
    end
    iaddr = 32'h3C; tick(); idle_inputs();
    check_val("wrap_ov", 32'(a_overflow), 32'd1);
    rd_req = 1; tick();
    check_val("wrap_first", 32'(a_reg_addr), 32'd3);
    check_val("stop_first", 32'(b_reg_addr), 32'd1);
    for (int i = 0; i < 4; i++) tick();
    idle_inputs();

    // Clear mid-capture; events in IDLE are not logged.
    clear = 1; tick(); idle_inputs();
    arm = 1; tick(); idle_inputs();
    reg_write(5'd7, 32'h77);
    clear = 1; tick(); idle_inputs();
    reg_write(5'd8, 32'h88);
    check_val("clear_count", 32'(a_count), 32'd0);

    // Randomised traffic.
    for (int n = 0; n < 600; n++) begin
      arm        = ($urandom % 12) == 0;
      clear      = ($urandom % 80) == 0;
      rf_wr      = $urandom % 2;
      rf_rd_addr = 5'($urandom % 8);
      rf_rd_data = $urandom;
      mem_wr_en  = ($urandom % 3) == 0;
      mem_addr   = $urandom;
      mem_data   = $urandom;
      mem_wr_mask = 4'($urandom % 16);
      iaddr      = (($urandom % 20) == 0) ? 32'h3C + ($urandom % 8) : ($urandom % 60);
      rd_req     = $urandom % 2;
      tick();
    end
    idle_inputs();

    // Asynchronous reset in the middle of capture.
    clear = 1; tick(); idle_inputs();
    arm = 1; tick(); idle_inputs();
    reg_write(5'd9, 32'h99);
    reg_write(5'd10, 32'hAA);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    check_val("areset_count", 32'(a_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_val("areset_state", 32'(b_state), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32i_trace_buffer.md
Name: rv32i_trace_buffer

Overview:
Synthesizable on-chip commit tracer for the rv32i SoC. It snoops base-register writes and data-memory writes, timestamps them, and stores them in a parametrised circular trace RAM. Capture stops when the instruction address reaches a halt threshold. Entries are then drained oldest-first over a request/valid port. It moves the end-of-program detection and the write logging that the simulation bench performs into hardware, so FPGA debug can use them.

Parameters:
DEPTH, 32, number of trace entries (power of two, at least 2)
HALT_PC, 32'h0000_003C, capture ends when iaddr >= HALT_PC
STOP_ON_FULL, 0, 0 = wrap and overwrite oldest; 1 = stop capture when full
TS_W, 16, timestamp width in cycles (wraps modulo 2^TS_W)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
arm  in  1  single-cycle pulse; starts capture from IDLE
clear  in  1  synchronous pulse; empties the buffer and returns to IDLE from any state
iaddr  in  32  core instruction address
rf_wr  in  1  base-register write enable
rf_rd_addr  in  5  base-register destination
rf_rd_data  in  32  base-register write data
mem_wr_en  in  1  data-memory write enable
mem_addr  in  32  data-memory byte address
mem_data  in  32  data-memory write data
mem_wr_mask  in  4  byte mask
rd_req  in  1  drain request; honoured only in DONE
rd_valid  out  1  entry fields valid this cycle
rd_has_reg, rd_has_mem  out  1 each  entry flags
rd_reg_addr  out  5  logged register address
rd_reg_data  out  32  logged register data
rd_mem_addr  out  32  logged memory address
rd_mem_data  out  32  logged memory data
rd_mem_mask  out  4  logged byte mask
rd_ts  out  TS_W  logged timestamp
state  out  2  0 IDLE, 1 CAPTURE, 2 DONE
count  out  $clog2(DEPTH)+1  valid entries held
overflow  out  1  sticky; set when an entry was lost or overwritten

Behaviour:
- Reset: state=IDLE, count=0, wr_ptr=rd_ptr=0, overflow=0, ts=0, rd_valid=0, all rd_* fields=0.
- Event qualification: reg_ev = rf_wr && rf_rd_addr!=0. mem_ev = mem_wr_en. When either is true, one entry is written. A cycle with both events produces a single entry with both flags set. A register write to x0 alone logs nothing.
- Timestamp counter: free-runs only in CAPTURE, clears on the arm pulse. The entry stores the ts value of the capture cycle.
- IDLE: events are ignored. arm -> CAPTURE next cycle, with ts=0, count=0, pointers=0, overflow=0.
- CAPTURE: events are logged on the same edge they occur.
  - Halt: iaddr >= HALT_PC (unsigned) -> DONE next cycle. An event in the halt cycle is still logged.
  - Full, STOP_ON_FULL=0: write at wr_ptr, advance rd_ptr, count stays DEPTH, overflow<=1.
  - Full, STOP_ON_FULL=1: the event is dropped, overflow<=1, state -> DONE.
  - arm while in CAPTURE is ignored.
- DONE: with rd_req and count>0, the entry at rd_ptr appears on rd_* with rd_valid=1 on the next cycle. rd_ptr then increments and count decrements.
  - Back-to-back rd_req gives one entry per cycle.
  - rd_req with count==0 gives rd_valid=0.
  - rd_valid is a one-cycle pulse. rd_* hold their last values otherwise.
- clear: highest priority after reset. Next cycle: IDLE, count=0, pointers=0, overflow=0, rd_valid=0.
- Pointers: wrap modulo DEPTH. Storage is a single-port-write, registered-read array.
- Asynchronous reset mid-capture discards all contents.

Decomposition:
- Shared package rv32i_dbg_pkg: state encodings (IDLE/CAPTURE/DONE) and the entry field widths/offsets. The packed entry width is 1+1+5+32+32+32+4+TS_W.
- One sub-module, trace_ram: a parametrised DEPTH x entry-width array with synchronous write and registered read. The FSM, pointers and counters stay in the top.

Test Plan:
- Reg write x5=0x12345678, then mem write addr 0x1000 data 0xDEADBEEF mask 1111, then iaddr=0x3C -> DONE, count=2, overflow=0. Drain returns the reg entry (ts=t0), then the mem entry, in order.
- Same cycle: rf_wr x1=0xA plus mem write 0x1004/0xB/0011 -> one entry, has_reg=has_mem=1, count=1. Write to x0 alone -> count unchanged.
- DEPTH=4, STOP_ON_FULL=0, 6 register writes x1..x6 -> count=4, overflow=1. Drain yields x3,x4,x5,x6.
- DEPTH=4, STOP_ON_FULL=1, 6 writes -> state=DONE after the 5th event, count=4, overflow=1. Drain yields x1..x4.
- Drain with count=0 -> rd_valid stays 0. clear during CAPTURE -> IDLE, count=0. Events after clear are not logged until arm.
- Assert rst_n=0 asynchronously mid-CAPTURE (off clock edge) -> outputs reach reset values immediately. After release, state=IDLE, count=0.
